// File: rtl/mult_seq_unit_pkg.sv
// rtl/mult_seq_unit_pkg.sv - shared state encodings, default width and funct codes for the MULT/MULTU path
package mult_seq_unit_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/mult_seq_unit_cla.sv
// rtl/mult_seq_unit_cla.sv - W-bit adder of cascaded 4-bit carry-lookahead cells (group PG/GG)
module cla_adder_nbit #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o
);
    localparam int NG = W / 4;

    logic [NG:0] gc;

    assign gc[0] = c_i;
    assign c_o   = gc[NG];

    for (genvar k = 0; k < NG; k++) begin : g_grp
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        logic       pg;
        logic       gg;

        assign p = a_i[4*k +: 4] ^ b_i[4*k +: 4];
        assign g = a_i[4*k +: 4] & b_i[4*k +: 4];

        assign c[0] = gc[k];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);

        // Group signals let the carry skip the cell without rippling through its bits.
        assign pg = &p;
        assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

        assign gc[k+1]        = gg | (pg & c[0]);
        assign sum_o[4*k +: 4] = p ^ c;
    end

endmodule

// File: rtl/mult_seq_unit.sv
// rtl/mult_seq_unit.sv - iterative shift-and-add MULT/MULTU unit with HI/LO; optional MULT_ZERO_SKIP_EN
module mult_seq_unit
    import mult_seq_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    state_t              state_q;
    logic [DATA_W-1:0]   mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [DATA_W-1:0]   acc_hi_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W-1:0]   addend;
    logic [DATA_W-1:0]   sum;
    logic                carry;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_d;

    // The most negative value maps onto 2^(W-1), which fits unsigned in W bits.
    assign a_mag  = (is_signed && a[DATA_W-1]) ? (~a + 1'b1) : a;
    assign b_mag  = (is_signed && b[DATA_W-1]) ? (~b + 1'b1) : b;
    assign addend = mplier_q[0] ? mcand_q : '0;
    assign prod   = {acc_hi_q, mplier_q};
    assign prod_d = neg_q ? (~prod + 1'b1) : prod;

    cla_adder_nbit #(.W(DATA_W)) u_acc_add (
        .a_i   (acc_hi_q),
        .b_i   (addend),
        .c_i   (1'b0),
        .sum_o (sum),
        .c_o   (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                        acc_hi_q <= '0;
                        cnt_q    <= CNT_W'(DATA_W);
                        busy_q   <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
                        if (a_mag == '0 || b_mag == '0) begin
                            mplier_q <= '0;
                            neg_q    <= 1'b0;
                            state_q  <= ST_FIN;
                        end else begin
                            state_q  <= ST_RUN;
                        end
`else
                        state_q  <= ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    acc_hi_q <= {carry, sum[DATA_W-1:1]};
                    mplier_q <= {sum[0], mplier_q[DATA_W-1:1]};
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    hi_q    <= prod_d[2*DATA_W-1:DATA_W];
                    lo_q    <= prod_d[DATA_W-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
